// File: rtl/me_pkg.sv
// Shared motion-estimation constants, candidate sideband type and pixel extraction helper.
package me_pkg;

    localparam int PIX_W   = 8;
    localparam int BLK_PIX = 64;
    localparam int MV_W    = 5;
    localparam int SAD_W   = 14;
    localparam int ROW_PIX = 8;
    localparam int ROWS    = BLK_PIX / ROW_PIX;
    localparam int BLK_W   = PIX_W * BLK_PIX;
    // A row sum of eight 8b differences peaks at 2040, which needs 11 bits.
    localparam int ROW_W   = PIX_W + 3;
    localparam int STAGES  = 3;

    // Sideband that travels with a candidate alongside the SAD data path.
    typedef struct packed {
        logic            first;
        logic            last;
        logic [MV_W-1:0] mv_x;
        logic [MV_W-1:0] mv_y;
    } cand_side_t;

    // Pixel k of a block: bits [8k+7:8k], row-major.
    function automatic logic [PIX_W-1:0] get_pix(input logic [BLK_W-1:0] blk,
                                                 input int unsigned      k);
        return blk[k*PIX_W +: PIX_W];
    endfunction

endpackage

// File: rtl/sad_tree.sv
// Three-stage SAD data path: per-pixel |cur-ref|, eight row sums, block total.
module sad_tree
    import me_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [BLK_W-1:0] cur_blk,
    input  logic [BLK_W-1:0] ref_blk,
    output logic [STAGES:1]  stage_vld,
    output logic [SAD_W-1:0] sad
);

    logic [STAGES:1]               vld_pipe_d, vld_pipe_q;
    logic [BLK_PIX-1:0][PIX_W-1:0] absd_d, absd_q;
    logic [ROWS-1:0][ROW_W-1:0]    row_d, row_q;
    logic [SAD_W-1:0]              sad_d, sad_q;

    // Valid shift register: bit s set means stage s holds a candidate.
    always_comb vld_pipe_d = {vld_pipe_q[STAGES-1:1], in_valid};

    // S1: one absolute-difference unit per pixel; the result always fits 8 bits.
    for (genvar k = 0; k < BLK_PIX; k++) begin : g_pix
        logic [PIX_W-1:0] c_px, r_px;
        assign c_px      = get_pix(cur_blk, k);
        assign r_px      = get_pix(ref_blk, k);
        assign absd_d[k] = (c_px > r_px) ? (c_px - r_px) : (r_px - c_px);
    end

    // S2: sum each row of eight differences.
    always_comb begin
        row_d = '0;
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < ROW_PIX; c++) begin
                row_d[r] = row_d[r] + ROW_W'(absd_q[r*ROW_PIX + c]);
            end
        end
    end

    // S3: add the eight row sums into the block SAD.
    always_comb begin
        sad_d = '0;
        for (int r = 0; r < ROWS; r++) begin
            sad_d = sad_d + SAD_W'(row_q[r]);
        end
    end

    // Valid bits are reset so a reset drops everything in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) vld_pipe_q <= '0;
        else     vld_pipe_q <= vld_pipe_d;
    end

    // Data registers need no reset; they are only observed with their valid bit.
    always_ff @(posedge clk) begin
        absd_q <= absd_d;
        row_q  <= row_d;
        sad_q  <= sad_d;
    end

    assign stage_vld = vld_pipe_q;
    assign sad       = sad_q;

endmodule

// File: rtl/sad_search_engine.sv
// SAD search engine: pipelined SAD per candidate, running minimum per block, one result per block.
module sad_search_engine
    import me_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic [BLK_W-1:0] cur_blk,
    input  logic [BLK_W-1:0] ref_blk,
    input  logic             cand_valid,
    input  logic             cand_first,
    input  logic             cand_last,
    input  logic [MV_W-1:0]  cand_mv_x,
    input  logic [MV_W-1:0]  cand_mv_y,
    output logic             busy,
    output logic             res_valid,
    output logic [SAD_W-1:0] best_sad,
    output logic [MV_W-1:0]  best_mv_x,
    output logic [MV_W-1:0]  best_mv_y
);

    logic [STAGES:1]              stage_vld;
    logic [SAD_W-1:0]             s3_sad;
    cand_side_t                   side_in, s3_side;
    cand_side_t [STAGES:1]        side_d, side_q;

    logic                         take;
    logic [SAD_W-1:0]             run_min_d, run_min_q;
    logic [MV_W-1:0]              run_mv_x_d, run_mv_x_q, run_mv_y_d, run_mv_y_q;
    logic [SAD_W-1:0]             best_sad_d, best_sad_q;
    logic [MV_W-1:0]              best_mv_x_d, best_mv_x_q, best_mv_y_d, best_mv_y_q;
    logic                         res_valid_d, res_valid_q;

    sad_tree u_tree (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (cand_valid),
        .cur_blk   (cur_blk),
        .ref_blk   (ref_blk),
        .stage_vld (stage_vld),
        .sad       (s3_sad)
    );

    // Sideband shift: flags are qualified at entry so bubbles never carry first/last.
    always_comb begin
        side_in.first = cand_valid & cand_first;
        side_in.last  = cand_valid & cand_last;
        side_in.mv_x  = cand_mv_x;
        side_in.mv_y  = cand_mv_y;
        side_d        = {side_q[STAGES-1:1], side_in};
    end

    assign s3_side = side_q[STAGES];

    // Sideband registers, cleared on reset so no stale first/last survives.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) side_q <= '0;
        else     side_q <= side_d;
    end

    // Compare: first reloads the minimum, otherwise a strictly smaller SAD wins
    // (ties keep the earlier candidate); last publishes the post-update minimum.
    always_comb begin
        run_min_d   = run_min_q;
        run_mv_x_d  = run_mv_x_q;
        run_mv_y_d  = run_mv_y_q;
        best_sad_d  = best_sad_q;
        best_mv_x_d = best_mv_x_q;
        best_mv_y_d = best_mv_y_q;
        res_valid_d = 1'b0;
        take        = stage_vld[STAGES] && (s3_side.first || (s3_sad < run_min_q));
        if (take) begin
            run_min_d  = s3_sad;
            run_mv_x_d = s3_side.mv_x;
            run_mv_y_d = s3_side.mv_y;
        end
        if (stage_vld[STAGES] && s3_side.last) begin
            best_sad_d  = run_min_d;
            best_mv_x_d = run_mv_x_d;
            best_mv_y_d = run_mv_y_d;
            res_valid_d = 1'b1;
        end
    end

    // Running minimum starts at all-ones so an orphan non-first candidate still lands.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            run_min_q   <= '1;
            run_mv_x_q  <= '0;
            run_mv_y_q  <= '0;
            best_sad_q  <= '0;
            best_mv_x_q <= '0;
            best_mv_y_q <= '0;
            res_valid_q <= 1'b0;
        end else begin
            run_min_q   <= run_min_d;
            run_mv_x_q  <= run_mv_x_d;
            run_mv_y_q  <= run_mv_y_d;
            best_sad_q  <= best_sad_d;
            best_mv_x_q <= best_mv_x_d;
            best_mv_y_q <= best_mv_y_d;
            res_valid_q <= res_valid_d;
        end
    end

    assign busy      = |stage_vld;
    assign res_valid = res_valid_q;
    assign best_sad  = best_sad_q;
    assign best_mv_x = best_mv_x_q;
    assign best_mv_y = best_mv_y_q;

endmodule

// File: tb/tb_sad_search_engine.sv
// Directed bench for sad_search_engine: single-candidate table plus multi-cycle sequences.
module tb_sad_search_engine;
    import me_pkg::*;

    logic             clk = 1'b0;
    logic             rst;
    logic [BLK_W-1:0] cur_blk, ref_blk;
    logic             cand_valid, cand_first, cand_last;
    logic [MV_W-1:0]  cand_mv_x, cand_mv_y;
    logic             busy, res_valid;
    logic [SAD_W-1:0] best_sad;
    logic [MV_W-1:0]  best_mv_x, best_mv_y;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int drv_cyc;

    typedef struct { int sad; int mx; int my; int cyc; } res_t;
    res_t res_q[$];

    typedef struct {
        logic [7:0] cur_px;
        logic [7:0] ref_px;
        int         mx;
        int         my;
        int         exp_sad;
    } vec_t;
    vec_t vecs[6];

    sad_search_engine dut (
        .clk        (clk),
        .rst        (rst),
        .cur_blk    (cur_blk),
        .ref_blk    (ref_blk),
        .cand_valid (cand_valid),
        .cand_first (cand_first),
        .cand_last  (cand_last),
        .cand_mv_x  (cand_mv_x),
        .cand_mv_y  (cand_mv_y),
        .busy       (busy),
        .res_valid  (res_valid),
        .best_sad   (best_sad),
        .best_mv_x  (best_mv_x),
        .best_mv_y  (best_mv_y)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Record every result pulse with the cycle it was seen in.
    always @(negedge clk) begin
        if (res_valid)
            res_q.push_back('{int'(best_sad), int'($signed(best_mv_x)),
                              int'($signed(best_mv_y)), cyc});
    end

    function automatic logic [BLK_W-1:0] fill(input logic [7:0] b);
        return {BLK_PIX{b}};
    endfunction

    // Reference block whose SAD against an all-zero block equals sad.
    function automatic logic [BLK_W-1:0] ref_for(input int sad);
        logic [BLK_W-1:0] blk;
        int rem, v;
        blk = '0;
        rem = sad;
        for (int k = 0; k < BLK_PIX; k++) begin
            v = (rem > 255) ? 255 : rem;
            blk[k*PIX_W +: PIX_W] = v[7:0];
            rem = rem - v;
        end
        return blk;
    endfunction

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic send(input logic [BLK_W-1:0] c, input logic [BLK_W-1:0] r,
                        input logic v, input logic f, input logic l,
                        input int mx, input int my);
        cur_blk    = c;
        ref_blk    = r;
        cand_valid = v;
        cand_first = f;
        cand_last  = l;
        cand_mv_x  = MV_W'(mx);
        cand_mv_y  = MV_W'(my);
        drv_cyc    = cyc;
        @(negedge clk); #1;
    endtask

    task automatic idle();
        cand_valid = 1'b0;
        cand_first = 1'b0;
        cand_last  = 1'b0;
    endtask

    task automatic drain(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic expect_res(input string name, input int sad, input int mx,
                              input int my, input int ecyc);
        res_t r;
        if (res_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s: no res_valid seen, expected sad %0d", name, sad);
        end else begin
            r = res_q.pop_front();
            chk({name, "_sad"}, r.sad, sad);
            chk({name, "_mvx"}, r.mx, mx);
            chk({name, "_mvy"}, r.my, my);
            chk({name, "_lat"}, r.cyc, ecyc);
        end
    endtask

    initial begin
        int e, e2;
        vecs[0] = '{8'h10, 8'h0C,   3,  -2,   256};
        vecs[1] = '{8'hFF, 8'h00, -16,  15, 16320};
        vecs[2] = '{8'h00, 8'hFF,  15, -16, 16320};
        vecs[3] = '{8'h80, 8'h80,   0,   0,     0};
        vecs[4] = '{8'h01, 8'h03,  -1,   1,   128};
        vecs[5] = '{8'h7F, 8'h80,   5,  -5,    64};

        rst = 1'b1;
        cur_blk = '0; ref_blk = '0; cand_mv_x = '0; cand_mv_y = '0;
        idle();
        drain(3);
        chk("rst_busy", busy, 0);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_best_sad", best_sad, 0);
        chk("rst_best_mvx", best_mv_x, 0);
        chk("rst_best_mvy", best_mv_y, 0);
        rst = 1'b0;
        drain(1);

        // Reset mid-stream discards the block.
        res_q.delete();
        send(fill(8'h00), ref_for(30), 1, 1, 0, 1, 1);
        send(fill(8'h00), ref_for(20), 1, 0, 0, 2, 2);
        send(fill(8'h00), ref_for(10), 1, 0, 1, 3, 3);
        idle();
        rst = 1'b1;
        @(negedge clk); #1;
        rst = 1'b0;
        drain(10);
        chk("midrst_no_result", res_q.size(), 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_best_sad", best_sad, 0);
        chk("midrst_best_mvx", best_mv_x, 0);
        chk("midrst_best_mvy", best_mv_y, 0);

        // Orphan non-first candidate after reset still beats the all-ones minimum.
        send(fill(8'h00), ref_for(200), 1, 0, 1, 4, -4);
        e = drv_cyc;
        idle();
        drain(6);
        expect_res("orphan", 200, 4, -4, e + 4);

        // Single-candidate blocks from the table.
        for (int i = 0; i < 6; i++) begin
            res_q.delete();
            send(fill(vecs[i].cur_px), fill(vecs[i].ref_px), 1, 1, 1, vecs[i].mx, vecs[i].my);
            e = drv_cyc;
            idle();
            chk($sformatf("vec%0d_busy", i), busy, 1);
            drain(6);
            expect_res($sformatf("vec%0d", i), vecs[i].exp_sad, vecs[i].mx, vecs[i].my, e + 4);
            chk($sformatf("vec%0d_idle", i), busy, 0);
            chk($sformatf("vec%0d_hold", i), best_sad, vecs[i].exp_sad);
        end

        // Four candidates, tie keeps the earlier one.
        res_q.delete();
        send(fill(8'h00), ref_for(500), 1, 1, 0, 0, 0);
        send(fill(8'h00), ref_for(120), 1, 0, 0, 1, 0);
        send(fill(8'h00), ref_for(120), 1, 0, 0, 2, 0);
        send(fill(8'h00), ref_for(300), 1, 0, 1, 3, 0);
        e = drv_cyc;
        idle();
        drain(6);
        expect_res("tie", 120, 1, 0, e + 4);
        chk("tie_single", res_q.size(), 0);

        // Back-to-back blocks: B must not inherit A's minimum.
        res_q.delete();
        send(fill(8'h00), ref_for(50), 1, 1, 0, 1, 1);
        send(fill(8'h00), ref_for(40), 1, 0, 1, 2, 2);
        e = drv_cyc;
        send(fill(8'h00), ref_for(90), 1, 1, 1, -1, -1);
        e2 = drv_cyc;
        idle();
        drain(7);
        expect_res("b2b_A", 40, 2, 2, e + 4);
        expect_res("b2b_B", 90, -1, -1, e2 + 4);

        // Bubbles with unqualified first/last pulses.
        res_q.delete();
        send(fill(8'h00), ref_for(70), 1, 1, 0, 0, 1);
        send(fill(8'h00), ref_for(5),  0, 1, 1, 7, 7);
        send(fill(8'h00), ref_for(60), 1, 0, 0, 0, 2);
        send(fill(8'h00), ref_for(5),  0, 0, 0, 7, 7);
        send(fill(8'h00), ref_for(80), 1, 0, 1, 0, 3);
        e = drv_cyc;
        send(fill(8'h00), ref_for(5),  0, 1, 1, 7, 7);
        idle();
        drain(8);
        expect_res("bubble", 60, 0, 2, e + 4);
        chk("bubble_no_extra", res_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
